// File: rtl/add16_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// add16_sequencer_pkg
//   Shared types for the multi-cycle word add/sub sequencer.
//   - state_t : sequencer FSM states (IDLE / RUN / DONE), 2-bit encoding
//   - flags_t : GB80-style flag bundle {Z, N, H, C}
//   - idx_width() : width of the slice index counter (never less than 1 bit)
// -----------------------------------------------------------------------------
package add16_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } flags_t;

    localparam flags_t FLAGS_CLEAR = '0;

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int idx_width(input int num_slices);
        return (num_slices > 1) ? $clog2(num_slices) : 1;
    endfunction

endpackage

// File: rtl/add16_sequencer_n_bit_adder.sv
// -----------------------------------------------------------------------------
// n_bit_adder
//   Combinational DATA_WIDTH-bit adder used as the shared slice of the
//   sequencer. It is built from a lower and an upper half-width segment so
//   the carry between the halves (the half carry) is available as an output.
// Ports
//   i_a, i_b     : addend slices
//   i_cin        : carry into bit 0
//   o_sum        : DATA_WIDTH-bit sum
//   o_cout       : carry out of the MSB
//   o_half_cout  : carry out of bit DATA_WIDTH/2-1 (equals i_cin when the
//                  slice is a single bit and has no lower half)
// -----------------------------------------------------------------------------
module n_bit_adder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_cin,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic                  o_cout,
    output logic                  o_half_cout
);

    localparam int LO_W = DATA_WIDTH / 2;
    localparam int HI_W = DATA_WIDTH - LO_W;

    generate
        if (LO_W == 0) begin : g_single
            logic [DATA_WIDTH:0] total;

            assign total       = {1'b0, i_a} + {1'b0, i_b} + {{DATA_WIDTH{1'b0}}, i_cin};
            assign o_sum       = total[DATA_WIDTH-1:0];
            assign o_cout      = total[DATA_WIDTH];
            assign o_half_cout = i_cin;
        end else begin : g_split
            logic [LO_W:0] lo;
            logic [HI_W:0] hi;

            // The lower segment's carry ripples into the upper segment.
            assign lo = {1'b0, i_a[LO_W-1:0]} + {1'b0, i_b[LO_W-1:0]}
                      + {{LO_W{1'b0}}, i_cin};
            assign hi = {1'b0, i_a[DATA_WIDTH-1:LO_W]} + {1'b0, i_b[DATA_WIDTH-1:LO_W]}
                      + {{HI_W{1'b0}}, lo[LO_W]};

            assign o_sum       = {hi[HI_W-1:0], lo[LO_W-1:0]};
            assign o_cout      = hi[HI_W];
            assign o_half_cout = lo[LO_W];
        end
    endgenerate

endmodule

// File: rtl/add16_sequencer.sv
// -----------------------------------------------------------------------------
// add16_sequencer
//   Performs a WORD_WIDTH-bit add or subtract by running one shared
//   SLICE_WIDTH-bit adder over NUM_SLICES consecutive cycles, chaining the
//   carry between slices, and reports GB80 flags (Z, N, H, C).
//   Subtraction is A + ~B + ~borrow; C and H are inverted back into borrow
//   sense on the way out.
//
// Build option
//   ADD16_SEQ_ZFLAG_EN : when defined, o_flag_z reports (o_result == 0);
//                        otherwise o_flag_z is constant 0 and no zero
//                        detector is built.
//
// Ports
//   i_clk, i_rst          : clock (rising edge), async active-high reset
//   i_valid / o_ready     : request handshake (accepted only in IDLE)
//   i_op_a, i_op_b        : operands
//   i_sub                 : 1 = A - B - borrow, 0 = A + B + carry
//   i_use_carry           : fold i_carry_in into slice 0
//   i_carry_in            : incoming C flag (carry for add, borrow for sub)
//   o_valid / i_ready     : result handshake, result held until accepted
//   o_result              : sum / difference
//   o_flag_z/n/h/c        : zero, subtract, half carry (top slice), carry
// -----------------------------------------------------------------------------
module add16_sequencer
    import add16_sequencer_pkg::*;
#(
    parameter int WORD_WIDTH  = 16,
    parameter int SLICE_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [WORD_WIDTH-1:0] i_op_a,
    input  logic [WORD_WIDTH-1:0] i_op_b,
    input  logic                  i_sub,
    input  logic                  i_use_carry,
    input  logic                  i_carry_in,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [WORD_WIDTH-1:0] o_result,
    output logic                  o_flag_z,
    output logic                  o_flag_n,
    output logic                  o_flag_h,
    output logic                  o_flag_c
);

    localparam int                NUM_SLICES = WORD_WIDTH / SLICE_WIDTH;
    localparam int                IDX_W      = idx_width(NUM_SLICES);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_SLICES - 1);

    state_t                  state;
    state_t                  state_next;

    logic [WORD_WIDTH-1:0]   op_a;
    logic [WORD_WIDTH-1:0]   op_b;      // already inverted for subtraction
    logic                    sub_q;
    logic                    carry_q;   // carry into the slice being processed
    logic [IDX_W-1:0]        idx;
    logic [WORD_WIDTH-1:0]   result_q;
    logic [WORD_WIDTH-1:0]   result_next;
    flags_t                  flags_q;

    logic                    carry_sel;
    logic                    cin0;
    logic                    last_slice;
    logic                    zero_next;

    logic [SLICE_WIDTH-1:0]  slice_a;
    logic [SLICE_WIDTH-1:0]  slice_b;
    logic [SLICE_WIDTH-1:0]  slice_sum;
    logic                    slice_cout;
    logic                    slice_half_cout;

    // Subtraction runs as A + ~B + 1, so an incoming borrow becomes a
    // missing +1 on slice 0.
    assign carry_sel  = i_use_carry & i_carry_in;
    assign cin0       = i_sub ^ carry_sel;
    assign last_slice = (idx == LAST_IDX);

    assign slice_a = op_a[idx*SLICE_WIDTH +: SLICE_WIDTH];
    assign slice_b = op_b[idx*SLICE_WIDTH +: SLICE_WIDTH];

    n_bit_adder #(
        .DATA_WIDTH (SLICE_WIDTH)
    ) u_slice_adder (
        .i_a         (slice_a),
        .i_b         (slice_b),
        .i_cin       (carry_q),
        .o_sum       (slice_sum),
        .o_cout      (slice_cout),
        .o_half_cout (slice_half_cout)
    );

    // Result as it will look after this cycle's slice is written; on the
    // last slice this is the final word, which feeds the zero detector.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, otherwise paths that skip an assignment infer a latch.
        result_next = result_q;
        result_next[idx*SLICE_WIDTH +: SLICE_WIDTH] = slice_sum;
    end

`ifdef ADD16_SEQ_ZFLAG_EN
    assign zero_next = (result_next == '0);
`else
    assign zero_next = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (i_valid)    state_next = ST_RUN;
            ST_RUN:  if (last_slice) state_next = ST_DONE;
            ST_DONE: if (i_ready)    state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state)
            ST_IDLE: o_ready = 1'b1;
            ST_DONE: o_valid = 1'b1;
            default: ;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: this block holds only a few flops, so all of it is reset;
        // a wide storage array would normally be left unreset instead.
        if (i_rst) begin
            op_a     <= '0;
            op_b     <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            idx      <= '0;
            result_q <= '0;
            flags_q  <= FLAGS_CLEAR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        op_a    <= i_op_a;
                        op_b    <= i_op_b ^ {WORD_WIDTH{i_sub}};
                        sub_q   <= i_sub;
                        carry_q <= cin0;
                        idx     <= '0;
                    end
                end
                ST_RUN: begin
                    result_q <= result_next;
                    carry_q  <= slice_cout;
                    if (last_slice) begin
                        idx     <= '0;
                        // Carries are inverted back to borrow sense for subtract.
                        flags_q <= '{z: zero_next,
                                     n: sub_q,
                                     h: slice_half_cout ^ sub_q,
                                     c: slice_cout ^ sub_q};
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_result = result_q;
    assign o_flag_z = flags_q.z;
    assign o_flag_n = flags_q.n;
    assign o_flag_h = flags_q.h;
    assign o_flag_c = flags_q.c;

endmodule

// File: tb/tb_add16_sequencer.sv
// -----------------------------------------------------------------------------
// tb_add16_sequencer
//   Scoreboard bench: the stimulus process pushes the expected response when a
//   request is accepted; an independent monitor pops and compares whenever the
//   DUT presents a result, and checks that held results stay stable.
//   Expected values come from plain integer arithmetic on whole words.
// -----------------------------------------------------------------------------
module tb_add16_sequencer;

    localparam int W  = 16;
    localparam int SW = 8;
    localparam int NS = W / SW;
    localparam int unsigned HM = (32'd1 << (W - SW / 2)) - 1;  // bits below the H position

    logic          i_clk;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  i_op_a;
    logic [W-1:0]  i_op_b;
    logic          i_sub;
    logic          i_use_carry;
    logic          i_carry_in;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_result;
    logic          o_flag_z;
    logic          o_flag_n;
    logic          o_flag_h;
    logic          o_flag_c;

    add16_sequencer #(
        .WORD_WIDTH  (W),
        .SLICE_WIDTH (SW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_op_a      (i_op_a),
        .i_op_b      (i_op_b),
        .i_sub       (i_sub),
        .i_use_carry (i_use_carry),
        .i_carry_in  (i_carry_in),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_flag_z    (o_flag_z),
        .o_flag_n    (o_flag_n),
        .o_flag_h    (o_flag_h),
        .o_flag_c    (o_flag_c)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         h;
        logic         c;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   holding    = 1'b0;
    int   bp_cycles  = 0;
    int   errors     = 0;
    int   checks     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Whole-word reference: plain add/subtract with carry/borrow and
    // half carry/borrow taken at the nibble boundary of the top slice.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic uc, input logic ci);
        exp_t        e;
        int unsigned ai;
        int unsigned bi;
        int unsigned k;
        int unsigned full;
        ai = a;
        bi = b;
        k  = (uc & ci) ? 1 : 0;
        if (!sub) begin
            full  = ai + bi + k;
            e.res = W'(full);
            e.c   = (full >= (32'd1 << W));
            e.h   = (((ai & HM) + (bi & HM) + k) > HM);
        end else begin
            full  = ai - bi - k;
            e.res = W'(full);
            e.c   = (ai < bi + k);
            e.h   = ((ai & HM) < (bi & HM) + k);
        end
        e.n = sub;
`ifdef ADD16_SEQ_ZFLAG_EN
        e.z = (e.res == '0);
`else
        e.z = 1'b0;
`endif
        e.acc = 0;
        return e;
    endfunction

    task automatic scramble();
        i_op_a      = W'($urandom);
        i_op_b      = W'($urandom);
        i_sub       = 1'($urandom_range(0, 1));
        i_use_carry = 1'($urandom_range(0, 1));
        i_carry_in  = 1'($urandom_range(0, 1));
    endtask

    // Waits for o_ready, presents the request, and records the expectation at
    // the accepting edge. While the DUT is busy it keeps i_valid high with
    // junk operands, which must be ignored.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic uc, input logic ci);
        exp_t e;
        bit   done;
        done = 1'b0;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge i_clk);
            if (o_ready) begin
                i_op_a      = a;
                i_op_b      = b;
                i_sub       = sub;
                i_use_carry = uc;
                i_carry_in  = ci;
                i_valid     = 1'b1;
                @(posedge i_clk);
                #1;
                e     = model(a, b, sub, uc, ci);
                e.acc = cyc;
                exp_q.push_back(e);
                i_valid = 1'b0;
                scramble();
                done = 1'b1;
            end else begin
                i_valid = 1'b1;
                scramble();
            end
        end
        check("accept_within_budget", 32'(done), 32'd1);
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 400 && !idle; t++) begin
            @(negedge i_clk);
            idle = (exp_q.size() == 0) && !holding && o_ready;
        end
        check("drain_complete", 32'(idle), 32'd1);
    endtask

    // Consumer: random backpressure, or forced low for bp_cycles result cycles.
    initial begin
        i_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            if (bp_cycles > 0) begin
                i_ready = 1'b0;
                if (o_valid) bp_cycles--;
            end else begin
                i_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                holding = 1'b0;
            end else if (o_valid) begin
                if (!holding) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("result",  32'(o_result), 32'(cur.res));
                        check("flag_z",  32'(o_flag_z), 32'(cur.z));
                        check("flag_n",  32'(o_flag_n), 32'(cur.n));
                        check("flag_h",  32'(o_flag_h), 32'(cur.h));
                        check("flag_c",  32'(o_flag_c), 32'(cur.c));
                        check("latency", 32'(cyc - cur.acc), 32'(NS));
                    end
                end else begin
                    check("held_result", 32'(o_result), 32'(cur.res));
                    check("held_flags", 32'({o_flag_z, o_flag_n, o_flag_h, o_flag_c}),
                          32'({cur.z, cur.n, cur.h, cur.c}));
                end
                check("ready_low_while_valid", 32'(o_ready), 32'd0);
                holding = !i_ready;
            end else if (holding) begin
                check("valid_held_until_ready", 32'(o_valid), 32'd1);
                holding = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        scramble();
        #1;
        check("reset_ready",  32'(o_ready),  32'd1);
        check("reset_valid",  32'(o_valid),  32'd0);
        check("reset_result", 32'(o_result), 32'd0);
        check("reset_flags",  32'({o_flag_z, o_flag_n, o_flag_h, o_flag_c}), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;

        // Directed cases
        send(16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        send(16'h1000, 16'h0001, 1'b1, 1'b0, 1'b0);
        send(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
        send(16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b1);
        send(16'h00FF, 16'h0000, 1'b0, 1'b0, 1'b1);
        send(16'h1234, 16'h0234, 1'b1, 1'b1, 1'b1);
        send(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
        drain();

        // Backpressure: result held for 5 clocks while a new request waits
        bp_cycles = 5;
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        drain();

        // Reset in the middle of RUN
        @(negedge i_clk);
        i_op_a      = 16'hABCD;
        i_op_b      = 16'h1111;
        i_sub       = 1'b0;
        i_use_carry = 1'b0;
        i_carry_in  = 1'b0;
        i_valid     = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        check("midrun_reset_valid",  32'(o_valid),  32'd0);
        check("midrun_reset_ready",  32'(o_ready),  32'd1);
        check("midrun_reset_result", 32'(o_result), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        send(16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        drain();

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
